// File: rtl/tt_sweep_checker_pkg.sv
// Shared FSM encodings and parameter limits for the truth-table sweep checker.
package tt_sweep_checker_pkg;

  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_APPLY = 2'd1,
    TT_DONE  = 2'd2
  } tt_state_e;

  localparam int TT_N_MIN      = 1;
  localparam int TT_N_MAX      = 8;
  localparam int TT_SETTLE_MAX = 15;

endpackage

// File: rtl/tt_vec_seq.sv
// Vector/hold counters: steps vec through 0..2^N-1, holding each for SETTLE+1 cycles.
// Latency: sample strobe is combinational from the registered counters.
// Backpressure: none; advances only while run is high.
module tt_vec_seq #(
  parameter int N      = 2,
  parameter int SETTLE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         run,
  output logic [N-1:0] vec,
  output logic         sample,
  output logic         last
);

  logic [3:0] hold;

  assign sample = run && (hold == 4'(SETTLE));
  assign last   = &vec;

  // vec stays on the final vector after the sweep so the caller can still see it
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vec  <= '0;
      hold <= '0;
    end else if (sample) begin
      hold <= '0;
      if (!last) vec <= vec + N'(1);
    end else if (run) begin
      hold <= hold + 4'd1;
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2^N inputs, captures res_a/res_b truth tables and counts mismatches.
// Latency: done pulses the cycle after edge E0+(SETTLE+1)*2^N; FIRST_MISMATCH_EN adds first-mismatch capture.
// Backpressure: none; start is ignored unless IDLE.
module tt_sweep_checker
  import tt_sweep_checker_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              res_a,
  input  logic              res_b,
  output logic [N-1:0]      vec,
  output logic              busy,
  output logic              done,
  output logic [(1<<N)-1:0] table_a,
  output logic [(1<<N)-1:0] table_b,
  output logic [N:0]        mismatch_cnt,
  output logic              equal
`ifdef FIRST_MISMATCH_EN
  ,
  output logic              first_mm_valid,
  output logic [N-1:0]      first_mm_vec
`endif
);

  if (N < TT_N_MIN || N > TT_N_MAX || SETTLE < 0 || SETTLE > TT_SETTLE_MAX) begin : g_bad_param
    $error("tt_sweep_checker: N or SETTLE out of range");
  end

  tt_state_e state_q, state_d;
  logic      accept, run, sample, last;

  assign accept = (state_q == TT_IDLE) && start;
  assign run    = (state_q == TT_APPLY);

  tt_vec_seq #(.N(N), .SETTLE(SETTLE)) u_seq (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .run    (run),
    .vec    (vec),
    .sample (sample),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= TT_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TT_IDLE:  if (start) state_d = TT_APPLY;
      TT_APPLY: if (sample && last) state_d = TT_DONE;
      TT_DONE:  state_d = TT_IDLE;
      default:  state_d = TT_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == TT_APPLY);
    done = (state_q == TT_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      table_a      <= '0;
      table_b      <= '0;
      mismatch_cnt <= '0;
    end else if (sample) begin
      table_a[vec] <= res_a;
      table_b[vec] <= res_b;
      if (res_a != res_b) mismatch_cnt <= mismatch_cnt + (N+1)'(1);
    end
  end

  assign equal = (mismatch_cnt == '0);

`ifdef FIRST_MISMATCH_EN
  // only the earliest disagreement of a sweep is latched
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      first_mm_valid <= 1'b0;
      first_mm_vec   <= '0;
    end else if (sample && (res_a != res_b) && !first_mm_valid) begin
      first_mm_valid <= 1'b1;
      first_mm_vec   <= vec;
    end
  end
`endif

endmodule
